// File: rtl/dtw_result_filter_if.sv
// Sink-FIFO pop port plus AXI-Stream master port of the DTW result filter.
// master = filter side, slave = FIFO / downstream side.
interface dtw_result_filter_if #(
  parameter int AXIS_WIDTH = 32
);
  logic                  fifo_empty;
  logic [AXIS_WIDTH-1:0] fifo_data;
  logic                  fifo_rden;
  logic [AXIS_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport master (
    input  fifo_empty, fifo_data, m_axis_tready,
    output fifo_rden, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output fifo_empty, fifo_data, m_axis_tready,
    input  fifo_rden, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/dtw_result_filter.sv
// Pops 3-word DTW results from a FWFT FIFO, thresholds the cost, and re-emits
// each record as a 3-beat AXI-Stream packet; keeps saturating hit/miss counters.
module dtw_result_filter #(
  parameter int AXIS_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter bit DROP_MISS  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [15:0]          threshold,
  dtw_result_filter_if.master  bus,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_QID, S_POS, S_MIN, S_EVAL, S_TX0, S_TX1, S_TX2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                state_q, state_d;
  logic [AXIS_WIDTH-1:0] qid_q, qid_d, pos_q, pos_d, tdata_q, tdata_d;
  logic [15:0]           minval_q, minval_d;
  logic                  hit_q, hit_d, tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic                  rd_state, pop, beat, hit_now;

  // rst_n gates the pop so nothing leaves the FIFO while reset is held
  assign rd_state = (state_q == S_QID) || (state_q == S_POS) || (state_q == S_MIN);
  assign pop      = rst_n & rd_state & ~bus.fifo_empty;
  assign beat     = tvalid_q & bus.m_axis_tready;
  assign hit_now  = (minval_q <= threshold);

  assign bus.fifo_rden     = pop;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign hit_count         = hit_cnt_q;
  assign miss_count        = miss_cnt_q;
  assign busy              = (state_q != S_QID);

  always_comb begin
    state_d    = state_q;
    qid_d      = qid_q;
    pos_d      = pos_q;
    minval_d   = minval_q;
    hit_d      = hit_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    case (state_q)
      S_QID: if (pop) begin
        qid_d   = bus.fifo_data;
        state_d = S_POS;
      end
      S_POS: if (pop) begin
        pos_d   = bus.fifo_data;
        state_d = S_MIN;
      end
      S_MIN: if (pop) begin
        minval_d = bus.fifo_data[15:0];
        state_d  = S_EVAL;
      end
      S_EVAL: begin
        hit_d = hit_now;
        if (hit_now) begin
          if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
        end else begin
          if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
        end
        if (DROP_MISS && !hit_now) begin
          state_d = S_QID;
        end else begin
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          tdata_d  = qid_q;
          state_d  = S_TX0;
        end
      end
      S_TX0: if (beat) begin
        tdata_d = pos_q;
        state_d = S_TX1;
      end
      S_TX1: if (beat) begin
        tdata_d = AXIS_WIDTH'({15'b0, hit_q, minval_q});
        tlast_d = 1'b1;
        state_d = S_TX2;
      end
      S_TX2: if (beat) begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        state_d  = S_QID;
      end
      default: state_d = S_QID;
    endcase

    // clear overrides any increment made by S_EVAL in the same cycle
    if (clear) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_QID;
      qid_q      <= '0;
      pos_q      <= '0;
      minval_q   <= '0;
      hit_q      <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      qid_q      <= qid_d;
      pos_q      <= pos_d;
      minval_q   <= minval_d;
      hit_q      <= hit_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_dtw_result_filter.sv
// Two filters (forwarding with 4-bit counters, dropping misses with 8-bit counters)
// fed from queue-modelled FWFT FIFOs; a per-instance monitor scores every beat.
module tb_dtw_result_filter;
  logic        clk = 1'b0, rst_n = 1'b0, clear0 = 1'b0, clear1 = 1'b0;
  logic [15:0] thr = 16'h0200;
  logic [3:0]  hc0, mc0;
  logic [7:0]  hc1, mc1;
  logic        busy0, busy1;

  dtw_result_filter_if #(.AXIS_WIDTH(32)) if0 ();
  dtw_result_filter_if #(.AXIS_WIDTH(32)) if1 ();

  dtw_result_filter #(.AXIS_WIDTH(32), .CNT_WIDTH(4), .DROP_MISS(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear0), .threshold(thr), .bus(if0),
    .hit_count(hc0), .miss_count(mc0), .busy(busy0));
  dtw_result_filter #(.AXIS_WIDTH(32), .CNT_WIDTH(8), .DROP_MISS(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .threshold(thr), .bus(if1),
    .hit_count(hc1), .miss_count(mc1), .busy(busy1));

  int total = 0, bad = 0, cyc = 0;
  logic [31:0] fq0[$], fq1[$];
  logic [32:0] eq0[$], eq1[$];
  int mh0 = 0, mm0 = 0, mh1 = 0, mm1 = 0;
  bit  pop0 = 0, pop1 = 0, hold0 = 0, hold1 = 0, tvp0 = 0;
  logic [32:0] prev0 = '0, prev1 = '0;
  int  popcnt0 = 0, popcnt1 = 0, lastpop0 = 0, rise0 = 0, lastbeat0 = 0;
  bit  stall_en = 0, rdy_rand = 0;
  bit  e0 = 1, e1 = 1, rr0 = 1, rr1 = 1, rdy0 = 1, rdy1 = 1;
  logic [31:0] d0 = '0, d1 = '0;

  assign if0.fifo_empty    = e0;
  assign if0.fifo_data     = d0;
  assign if0.m_axis_tready = rdy_rand ? rr0 : rdy0;
  assign if1.fifo_empty    = e1;
  assign if1.fifo_data     = d1;
  assign if1.m_axis_tready = rdy_rand ? rr1 : rdy1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  // FIFO heads and random ready/stall update just after each rising edge
  always @(posedge clk) begin
    #1;
    if (pop0) begin if (fq0.size() > 0) void'(fq0.pop_front()); pop0 = 0; end
    if (pop1) begin if (fq1.size() > 0) void'(fq1.pop_front()); pop1 = 0; end
    e0 = (fq0.size() == 0) || (stall_en && $urandom_range(0, 3) == 0);
    d0 = (fq0.size() > 0) ? fq0[0] : 32'h0;
    e1 = (fq1.size() == 0) || (stall_en && $urandom_range(0, 3) == 0);
    d1 = (fq1.size() > 0) ? fq1[0] : 32'h0;
    rr0 = ($urandom_range(0, 2) != 0);
    rr1 = ($urandom_range(0, 2) != 0);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hold0 = 0; tvp0 = 0; popcnt0 = 0;
      chk("rst_rden0", if0.fifo_rden, 0);
      chk("rst_tvalid0", if0.m_axis_tvalid, 0);
    end else begin
      if (if0.fifo_rden) begin
        chk("rden_nonempty0", if0.fifo_empty, 0);
        pop0 = 1; popcnt0++;
        if (popcnt0 % 3 == 0) lastpop0 = cyc;
      end
      if (hold0) begin
        chk("hold_valid0", if0.m_axis_tvalid, 1);
        chk("hold_beat0", {if0.m_axis_tlast, if0.m_axis_tdata}, prev0);
      end
      if (if0.m_axis_tvalid && !tvp0) rise0 = cyc;
      if (if0.m_axis_tvalid && if0.m_axis_tready) begin
        if (eq0.size() == 0) begin
          total++; bad++;
          $display("FAIL beat0: got %0h want none", {if0.m_axis_tlast, if0.m_axis_tdata});
        end else chk("beat0", {if0.m_axis_tlast, if0.m_axis_tdata}, eq0.pop_front());
        lastbeat0 = cyc;
      end
      hold0 = if0.m_axis_tvalid && !if0.m_axis_tready;
      prev0 = {if0.m_axis_tlast, if0.m_axis_tdata};
      tvp0  = if0.m_axis_tvalid;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hold1 = 0; popcnt1 = 0;
      chk("rst_rden1", if1.fifo_rden, 0);
      chk("rst_tvalid1", if1.m_axis_tvalid, 0);
    end else begin
      if (if1.fifo_rden) begin
        chk("rden_nonempty1", if1.fifo_empty, 0);
        pop1 = 1; popcnt1++;
      end
      if (hold1) begin
        chk("hold_valid1", if1.m_axis_tvalid, 1);
        chk("hold_beat1", {if1.m_axis_tlast, if1.m_axis_tdata}, prev1);
      end
      if (if1.m_axis_tvalid && if1.m_axis_tready) begin
        if (eq1.size() == 0) begin
          total++; bad++;
          $display("FAIL beat1: got %0h want none", {if1.m_axis_tlast, if1.m_axis_tdata});
        end else chk("beat1", {if1.m_axis_tlast, if1.m_axis_tdata}, eq1.pop_front());
      end
      hold1 = if1.m_axis_tvalid && !if1.m_axis_tready;
      prev1 = {if1.m_axis_tlast, if1.m_axis_tdata};
    end
  end

  // Reference: queue the words, predict the packet and the counters
  task automatic send(input bit m0, input bit m1, input logic [31:0] q, input logic [31:0] p,
                      input logic [15:0] mv, input int nw);
    logic [31:0] w3;
    bit h;
    w3 = {16'($urandom), mv};
    h  = (mv <= thr);
    if (m0) begin
      fq0.push_back(q);
      if (nw == 3) begin fq0.push_back(p); fq0.push_back(w3); end
      eq0.push_back({1'b0, q}); eq0.push_back({1'b0, p});
      eq0.push_back({1'b1, 15'b0, h, mv});
      if (h) mh0 = sat(mh0, 15); else mm0 = sat(mm0, 15);
    end
    if (m1) begin
      fq1.push_back(q); fq1.push_back(p); fq1.push_back(w3);
      if (h) begin
        eq1.push_back({1'b0, q}); eq1.push_back({1'b0, p});
        eq1.push_back({1'b1, 15'b0, h, mv});
        mh1 = sat(mh1, 255);
      end else mm1 = sat(mm1, 255);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (n < 3000 && (fq0.size() != 0 || fq1.size() != 0 || eq0.size() != 0 ||
               eq1.size() != 0 || busy0 || busy1 || if0.m_axis_tvalid || if1.m_axis_tvalid));
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL %s_timeout: got busy want idle", tag);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_hit0"}, hc0, mh0);
    chk({tag, "_miss0"}, mc0, mm0);
    chk({tag, "_hit1"}, hc1, mh1);
    chk({tag, "_miss1"}, mc1, mm1);
  endtask

  task automatic wait_pops(input int target, input string tag);
    int n = 0;
    while (popcnt0 < target && n < 100) begin @(posedge clk); #1; n++; end
    chk({tag, "_pops"}, popcnt0, target);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tdata0", if0.m_axis_tdata, 0);
    chk("rst_tlast0", if0.m_axis_tlast, 0);
    chk("rst_busy0", busy0, 0);
    chk_cnt("rst");
    rst_n = 1'b1;

    // basic hit, latency, back-to-back beats
    send(1, 1, 32'h5, 32'h1234, 16'h0100, 3);
    wait_idle("t1");
    chk_cnt("t1");
    chk("t1_latency", rise0 - lastpop0, 2);
    chk("t1_b2b", lastbeat0 - rise0, 2);

    // miss, then a record after a dropped one, then threshold boundary
    send(1, 1, 32'h6, 32'h22, 16'h0300, 3);
    send(1, 1, 32'h7, 32'h33, 16'h0150, 3);
    send(1, 1, 32'h8, 32'h44, 16'h0200, 3);
    send(1, 1, 32'h9, 32'h45, 16'h0201, 3);
    wait_idle("t2");
    chk_cnt("t2");

    // backpressure during the position beat
    rdy0 = 1'b0;
    send(1, 0, 32'hA, 32'h1234, 16'h0010, 3);
    for (int i = 0; i < 20 && !if0.m_axis_tvalid; i++) begin @(posedge clk); #1; end
    chk("t4_valid", if0.m_axis_tvalid, 1);
    rdy0 = 1'b1;
    @(posedge clk); #1;
    rdy0 = 1'b0;
    repeat (5) begin @(posedge clk); #1; chk("t4_hold", if0.m_axis_tdata, 32'h1234); end
    rdy0 = 1'b1;
    wait_idle("t4");

    // FIFO empty between words 1 and 2
    base = popcnt0;
    send(1, 0, 32'hB, 32'h55, 16'h0077, 1);
    wait_pops(base + 1, "t5a");
    repeat (4) begin @(negedge clk); chk("t5_gap_rden", if0.fifo_rden, 0); end
    fq0.push_back(32'h55); fq0.push_back(32'hFFFF_0077);
    wait_idle("t5");
    chk_cnt("t5");

    // saturation
    for (int i = 0; i < 17; i++) send(1, 1, i, i + 100, 16'h0010, 3);
    wait_idle("sat");
    chk("sat_hit0", hc0, 15);
    chk_cnt("sat");

    clear0 = 1'b1; clear1 = 1'b1;
    @(posedge clk); #1;
    clear0 = 1'b0; clear1 = 1'b0;
    mh0 = 0; mm0 = 0; mh1 = 0; mm1 = 0;
    chk_cnt("clr");

    // clear coincident with the evaluation cycle of a hit
    base = popcnt0;
    send(1, 0, 32'hC, 32'hC1, 16'h0001, 3);
    wait_pops(base + 3, "clrev");
    clear0 = 1'b1;
    @(posedge clk); #1;
    clear0 = 1'b0;
    mh0 = 0; mm0 = 0;
    wait_idle("clrev");
    chk("clrev_hit0", hc0, 0);

    // randomized phases with stalls and random ready
    stall_en = 1; rdy_rand = 1;
    for (int ph = 0; ph < 4; ph++) begin
      thr = 16'($urandom);
      for (int r = 0; r < 12; r++) begin
        logic [15:0] mv;
        mv = ($urandom_range(0, 1) == 0) ? 16'(thr + 16'($urandom_range(0, 4)) - 16'd2)
                                         : 16'($urandom);
        send(1, 1, $urandom, $urandom, mv, 3);
      end
      wait_idle("rnd");
      chk_cnt("rnd");
    end
    stall_en = 0; rdy_rand = 0;

    // reset with a partial record in flight
    thr = 16'h0200;
    base = popcnt0;
    fq0.push_back(32'hA0); fq0.push_back(32'hB0);
    wait_pops(base + 2, "t6a");
    chk("t6_busy_pre", busy0, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy0, 0);
    chk("t6_tvalid", if0.m_axis_tvalid, 0);
    chk("t6_rden", if0.fifo_rden, 0);
    mh0 = 0; mm0 = 0; mh1 = 0; mm1 = 0;
    chk_cnt("t6r");
    send(1, 0, 32'h9, 32'h77, 16'h0010, 3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_idle("t6");
    chk_cnt("t6");
    chk("left0", eq0.size(), 0);
    chk("left1", eq1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
endmodule
